// File: rtl/ir_packet_decoder.sv
// rtl/ir_packet_decoder.sv - IR car-link packet decoder (start, select, 4 command bits)
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   IR_IN      demodulated IR envelope, 1 = carrier present, asynchronous
//   CMD        {RIGHT,LEFT,BACK,FORWARD}, held between packets, forced 0 on link loss
//   CMD_VALID  one-cycle strobe when CMD is updated by a good packet
//   PKT_ERR    one-cycle strobe when a packet is aborted
//   LINK_LOST  high while no good packet has arrived within TIMEOUT_MS
module ir_packet_decoder #(
    parameter int TICK_DIV   = 50,
    parameter int START_US   = 2400,
    parameter int SELECT_US  = 600,
    parameter int GAP_US     = 600,
    parameter int ONE_US     = 1200,
    parameter int ZERO_US    = 600,
    parameter int TOL_PCT    = 25,
    parameter int TIMEOUT_MS = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IR_IN,
    output logic [3:0] CMD,
    output logic       CMD_VALID,
    output logic       PKT_ERR,
    output logic       LINK_LOST
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [15:0] START_MIN  = 16'(START_US  * (100 - TOL_PCT) / 100);
    localparam logic [15:0] START_MAX  = 16'(START_US  * (100 + TOL_PCT) / 100);
    localparam logic [15:0] SELECT_MIN = 16'(SELECT_US * (100 - TOL_PCT) / 100);
    localparam logic [15:0] SELECT_MAX = 16'(SELECT_US * (100 + TOL_PCT) / 100);
    localparam logic [15:0] GAP_MIN    = 16'(GAP_US    * (100 - TOL_PCT) / 100);
    localparam logic [15:0] GAP_MAX    = 16'(GAP_US    * (100 + TOL_PCT) / 100);
    localparam logic [15:0] ONE_MIN    = 16'(ONE_US    * (100 - TOL_PCT) / 100);
    localparam logic [15:0] ONE_MAX    = 16'(ONE_US    * (100 + TOL_PCT) / 100);
    localparam logic [15:0] ZERO_MIN   = 16'(ZERO_US   * (100 - TOL_PCT) / 100);
    localparam logic [15:0] ZERO_MAX   = 16'(ZERO_US   * (100 + TOL_PCT) / 100);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_SELECT,
        S_BIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_n;
    state_t gap_next, gap_next_n;

    logic          ir_s1, ir_s2, ir_s3;
    logic          rise, fall;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [15:0]   len_cnt;
    logic [3:0]    shift, shift_n;
    logic [1:0]    bit_cnt, bit_cnt_n;
    logic [9:0]    ms_sub;
    logic [15:0]   ms_cnt;
    logic          done_evt, err_evt, timeout_evt;

    function automatic logic in_win(input logic [15:0] v, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ir_s1 <= 1'b0;
            ir_s2 <= 1'b0;
            ir_s3 <= 1'b0;
        end else begin
            ir_s1 <= IR_IN;
            ir_s2 <= ir_s1;
            ir_s3 <= ir_s2;
        end
    end

    assign rise = ir_s2 & ~ir_s3;
    assign fall = ~ir_s2 & ir_s3;
    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    // Free-running 1 us prescaler and burst/gap length counter in ticks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_cnt <= '0;
            len_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (rise || fall)
                len_cnt <= '0;
            else if (tick && (len_cnt != 16'hFFFF))
                len_cnt <= len_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            gap_next <= S_SELECT;
            shift    <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_n;
            gap_next <= gap_next_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
        end
    end

    // Inside a burst state the synchronised line is high unless this is the
    // falling-edge cycle, so "no fall" means the carrier is still present.
    always_comb begin
        state_n    = state;
        gap_next_n = gap_next;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n   = S_START;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            S_START: begin
                if (fall) begin
                    if (in_win(len_cnt, START_MIN, START_MAX)) begin
                        state_n    = S_GAP;
                        gap_next_n = S_SELECT;
                    end else begin
                        state_n = S_ERROR;
                    end
                end else if (len_cnt > START_MAX) begin
                    state_n = S_ERROR;
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_n = in_win(len_cnt, GAP_MIN, GAP_MAX) ? gap_next : S_ERROR;
                end else if (len_cnt > GAP_MAX) begin
                    state_n = S_ERROR;
                end
            end
            S_SELECT: begin
                if (fall) begin
                    if (in_win(len_cnt, SELECT_MIN, SELECT_MAX)) begin
                        state_n    = S_GAP;
                        gap_next_n = S_BIT;
                    end else begin
                        state_n = S_ERROR;
                    end
                end else if (len_cnt > SELECT_MAX) begin
                    state_n = S_ERROR;
                end
            end
            S_BIT: begin
                if (fall) begin
                    if (in_win(len_cnt, ZERO_MIN, ZERO_MAX) ||
                        in_win(len_cnt, ONE_MIN, ONE_MAX)) begin
                        shift_n    = {shift[2:0], in_win(len_cnt, ONE_MIN, ONE_MAX)};
                        bit_cnt_n  = bit_cnt + 2'd1;
                        gap_next_n = S_BIT;
                        state_n    = (bit_cnt == 2'd3) ? S_DONE : S_GAP;
                    end else begin
                        state_n = S_ERROR;
                    end
                end else if (len_cnt > ONE_MAX) begin
                    state_n = S_ERROR;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERROR: begin
                state_n   = S_IDLE;
                shift_n   = '0;
                bit_cnt_n = '0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // DONE and ERROR are only ever entered from another state, so the
    // strobes are registered on entry and line up with the updated CMD.
    assign done_evt    = (state_n == S_DONE);
    assign err_evt     = (state_n == S_ERROR);
    assign timeout_evt = !LINK_LOST && tick && (ms_sub == 10'd999) &&
                         (ms_cnt == 16'(TIMEOUT_MS - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CMD       <= '0;
            CMD_VALID <= 1'b0;
            PKT_ERR   <= 1'b0;
            LINK_LOST <= 1'b1;
            ms_sub    <= '0;
            ms_cnt    <= '0;
        end else begin
            CMD_VALID <= done_evt;
            PKT_ERR   <= err_evt;
            // A good packet takes priority over a coincident timeout expiry.
            if (done_evt) begin
                CMD       <= shift_n;
                LINK_LOST <= 1'b0;
                ms_sub    <= '0;
                ms_cnt    <= '0;
            end else if (!LINK_LOST && tick) begin
                if (ms_sub == 10'd999) begin
                    ms_sub <= '0;
                    ms_cnt <= ms_cnt + 16'd1;
                end else begin
                    ms_sub <= ms_sub + 10'd1;
                end
                if (timeout_evt) begin
                    LINK_LOST <= 1'b1;
                    CMD       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_packet_decoder.sv
// tb/tb_ir_packet_decoder.sv - scoreboard bench for ir_packet_decoder
module tb_ir_packet_decoder;

    localparam int TD    = 2;
    localparam int START = 48;
    localparam int SEL   = 12;
    localparam int GAP   = 12;
    localparam int ONE   = 24;
    localparam int ZERO  = 12;
    localparam int TOL   = 25;
    localparam int TMO   = 3;
    localparam int START_MAX = START * (100 + TOL) / 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ir = 1'b0;
    logic [3:0] cmd;
    logic       cmd_valid, pkt_err, link_lost;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic [4:0] sb[$];
    logic [3:0] exp_cmd = 4'h0;

    ir_packet_decoder #(
        .TICK_DIV(TD), .START_US(START), .SELECT_US(SEL), .GAP_US(GAP),
        .ONE_US(ONE), .ZERO_US(ZERO), .TOL_PCT(TOL), .TIMEOUT_MS(TMO)
    ) dut (
        .CLK(clk), .RST(rst_n), .IR_IN(ir), .CMD(cmd),
        .CMD_VALID(cmd_valid), .PKT_ERR(pkt_err), .LINK_LOST(link_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {is_error, cmd} expected for every strobe the DUT emits.
    always @(negedge clk) begin
        if (rst_n && (cmd_valid || pkt_err)) begin
            tests_run++;
            if (cmd_valid && pkt_err) begin
                tests_failed++;
                $display("FAIL sb_both: CMD_VALID and PKT_ERR high together at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got err=%0b cmd=%b, expected no event", pkt_err, cmd);
            end else begin
                logic [4:0] exp;
                exp = sb.pop_front();
                if ({pkt_err, cmd} !== exp) begin
                    tests_failed++;
                    $display("FAIL sb_event: got err=%0b cmd=%b, expected err=%0b cmd=%b",
                             pkt_err, cmd, exp[4], exp[3:0]);
                end
            end
            if (cmd_valid) begin
                valid_cyc = cyc;
                valid_cnt++;
            end else begin
                err_cnt++;
            end
        end
    end

    task automatic drive(input logic lvl, input int ticks);
        ir = lvl;
        repeat (ticks * TD) @(posedge clk);
        #1;
    endtask

    task automatic burst(input int hi);
        drive(1'b1, hi);
        last_fall_cyc = cyc;
        drive(1'b0, GAP);
    endtask

    task automatic send_packet(input logic [3:0] c);
        sb.push_back({1'b0, c});
        exp_cmd = c;
        burst(START);
        burst(SEL);
        for (int i = 3; i >= 0; i--) burst(c[i] ? ONE : ZERO);
        drive(1'b0, 20);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({cmd, cmd_valid, pkt_err, link_lost} !== 7'b0000_001) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cmd=%b v=%b e=%b lost=%b, expected 0000 0 0 1",
                     cmd, cmd_valid, pkt_err, link_lost);
        end
        rst_n = 1'b1;
        drive(1'b0, 10);
    endtask

    task automatic test_good_packet;
        int v0;
        v0 = valid_cnt;
        send_packet(4'b1010);
        check_int("good_valid_count", valid_cnt, v0 + 1);
        check_int("good_cmd", int'(cmd), 'b1010);
        check_int("good_link_lost", int'(link_lost), 0);
        check_int("good_latency", valid_cyc - last_fall_cyc, 3);
    endtask

    task automatic test_bad_start;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        sb.push_back({1'b1, exp_cmd});
        burst(30);
        drive(1'b0, 20);
        check_int("bad_start_err", err_cnt, e0 + 1);
        check_int("bad_start_no_valid", valid_cnt, v0);
        check_int("bad_start_cmd_hold", int'(cmd), 'b1010);
        send_packet(4'b0001);
        check_int("after_bad_start_cmd", int'(cmd), 'b0001);
    endtask

    task automatic test_bad_bit;
        int e0;
        send_packet(4'b1010);
        e0 = err_cnt;
        sb.push_back({1'b1, exp_cmd});
        burst(START);
        burst(SEL);
        burst(ONE);
        burst(17);
        drive(1'b0, 20);
        check_int("bad_bit_err", err_cnt, e0 + 1);
        check_int("bad_bit_cmd_hold", int'(cmd), 'b1010);
    endtask

    task automatic test_stuck_high;
        int n, v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        n = 0;
        sb.push_back({1'b1, exp_cmd});
        ir = 1'b1;
        while (!pkt_err && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (n < 2 * START_MAX + 2 || n > 2 * START_MAX + 8) begin
            tests_failed++;
            $display("FAIL stuck_err_time: got %0d cycles, expected %0d..%0d",
                     n, 2 * START_MAX + 2, 2 * START_MAX + 8);
        end
        repeat (800) @(posedge clk);
        #1;
        check_int("stuck_single_err", err_cnt, e0 + 1);
        check_int("stuck_no_valid", valid_cnt, v0);
        drive(1'b0, 20);
        check_int("stuck_no_rearm_err", err_cnt, e0 + 1);
        send_packet(4'b0110);
        check_int("after_stuck_cmd", int'(cmd), 'b0110);
    endtask

    task automatic test_link_lost;
        int n;
        send_packet(4'b1100);
        drive(1'b0, 100);
        send_packet(4'b0011);
        n = 0;
        while (!link_lost && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (!link_lost) begin
            tests_failed++;
            $display("FAIL lost_timeout: LINK_LOST got 0 after %0d cycles, expected 1", n);
        end else begin
            tests_run++;
            if ((cyc - valid_cyc) < TMO * 1000 * TD - TD ||
                (cyc - valid_cyc) > TMO * 1000 * TD + TD) begin
                tests_failed++;
                $display("FAIL lost_time: got %0d cycles, expected %0d +/- %0d",
                         cyc - valid_cyc, TMO * 1000 * TD, TD);
            end
        end
        check_int("lost_cmd_zero", int'(cmd), 0);
        exp_cmd = 4'h0;
        send_packet(4'b1001);
        check_int("restore_cmd", int'(cmd), 'b1001);
        check_int("restore_link", int'(link_lost), 0);
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        burst(START);
        burst(SEL);
        burst(ONE);
        burst(ZERO);
        drive(1'b1, 10);
        rst_n = 1'b0;
        #1;
        check_int("mid_rst_cmd", int'(cmd), 0);
        check_int("mid_rst_lost", int'(link_lost), 1);
        check_int("mid_rst_valid", int'(cmd_valid), 0);
        drive(1'b1, 5);
        drive(1'b0, 20);
        rst_n = 1'b1;
        drive(1'b0, 20);
        check_int("mid_rst_no_valid", valid_cnt, v0);
        check_int("mid_rst_no_err", err_cnt, e0);
        check_int("mid_rst_cmd_after", int'(cmd), 0);
        exp_cmd = 4'h0;
        send_packet(4'b0101);
        check_int("post_rst_cmd", int'(cmd), 'b0101);
        check_int("post_rst_link", int'(link_lost), 0);
    endtask

    task automatic test_back_to_back;
        int v0;
        logic [3:0] c;
        v0 = valid_cnt;
        send_packet(4'b0000);
        send_packet(4'b1111);
        for (int i = 0; i < 4; i++) begin
            c = 4'($urandom_range(0, 15));
            send_packet(c);
            check_int("b2b_cmd", int'(cmd), int'(c));
        end
        check_int("b2b_count", valid_cnt, v0 + 6);
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_start();
        test_bad_bit();
        test_stuck_high();
        test_link_lost();
        test_reset_mid();
        test_back_to_back();
        check_int("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
